// File: rtl/change_dispenser.sv
// Greedy coin payout engine: pays an amount from five coin tubes, largest first,
// skipping empty tubes, with a four-phase req/ack handshake and an ack timeout.
module change_dispenser #(
  parameter int DEN0        = 20,
  parameter int DEN1        = 10,
  parameter int DEN2        = 5,
  parameter int DEN3        = 2,
  parameter int DEN4        = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] change_amount,
  input  logic       change_valid,
  input  logic [4:0] coin_empty,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [2:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       short_change,
  output logic       fault,
  output logic [7:0] remaining
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           r_state, w_state_next;
  logic             r_coin_req, w_coin_req_next;
  logic [2:0]       r_coin_type, w_coin_type_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_short, w_short_next;
  logic             r_fault, w_fault_next;
  logic [7:0]       r_remaining, w_remaining_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_sel_found;
  logic [2:0]       w_sel_idx;

  function automatic logic [7:0] den_of(input logic [2:0] idx);
    case (idx)
      3'd0:    den_of = 8'(DEN0);
      3'd1:    den_of = 8'(DEN1);
      3'd2:    den_of = 8'(DEN2);
      3'd3:    den_of = 8'(DEN3);
      default: den_of = 8'(DEN4);
    endcase
  endfunction

  // Scan from the smallest tube upward so the lowest eligible index wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (den_of(3'(i)) <= r_remaining && !coin_empty[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_coin_req_next  = r_coin_req;
    w_coin_type_next = r_coin_type;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_short_next     = r_short;
    w_fault_next     = r_fault;
    w_remaining_next = r_remaining;
    w_cnt_next       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (change_valid) begin
          w_remaining_next = change_amount;
          w_short_next     = 1'b0;
          if (change_amount != 8'd0) begin
            w_busy_next  = 1'b1;
            w_state_next = S_SELECT;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_SELECT: begin
        if (r_remaining == 8'd0) begin
          w_state_next = S_DONE;
        end else if (w_sel_found) begin
          w_coin_type_next = w_sel_idx;
          w_cnt_next       = '0;
          w_state_next     = S_REQ;
        end else begin
          w_short_next = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_REQ: begin
        // An ack only counts once the request is actually visible to the hopper.
        if (r_coin_req && coin_ack) begin
          w_remaining_next = r_remaining - den_of(r_coin_type);
          w_coin_req_next  = 1'b0;
          w_state_next     = S_GAP;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_coin_req_next = 1'b0;
          w_fault_next    = 1'b1;
          w_busy_next     = 1'b1;
          w_state_next    = S_FAULT;
        end else begin
          w_cnt_next      = r_cnt + 1'b1;
          w_coin_req_next = 1'b1;
        end
      end
      S_GAP: begin
        if (!coin_ack) w_state_next = S_SELECT;
      end
      S_DONE: begin
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      S_FAULT: begin
        w_coin_req_next = 1'b0;
        w_busy_next     = 1'b1;
        w_fault_next    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_coin_req  <= 1'b0;
      r_coin_type <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= 8'd0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_coin_req  <= w_coin_req_next;
      r_coin_type <= w_coin_type_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_short     <= w_short_next;
      r_fault     <= w_fault_next;
      r_remaining <= w_remaining_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign coin_req     = r_coin_req;
  assign coin_type    = r_coin_type;
  assign busy         = r_busy;
  assign done         = r_done;
  assign short_change = r_short;
  assign fault        = r_fault;
  assign remaining    = r_remaining;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out the change amount produced by the vending money logic as a sequence of individual coins from a five-tube coin hopper. It uses a greedy largest-coin-first algorithm and skips empty tubes. It drives a four-phase req/ack handshake towards the hopper mechanism. It sits downstream of the money/dispense controller and is started by its change strobe.

Parameters:
DEN0, 20, value of coin tube 0 (largest)
DEN1, 10, value of coin tube 1
DEN2, 5, value of coin tube 2
DEN3, 2, value of coin tube 3
DEN4, 1, value of coin tube 4 (smallest); DEN0..DEN4 strictly descending, all nonzero
ACK_TIMEOUT, 16, max cycles coin_req may stay high without coin_ack before fault

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
change_amount  input  8  change to pay in rupees, sampled with change_valid
change_valid  input  1  one-cycle start strobe
coin_empty  input  5  bit i = 1: tube i empty, sampled in SELECT
coin_ack  input  1  hopper has ejected the requested coin
coin_req  output  1  request one coin of type coin_type
coin_type  output  3  tube index 0..4 being requested
busy  output  1  payout in progress
done  output  1  one-cycle pulse at payout end
short_change  output  1  last payout could not be completed; valid with done, held until next start
fault  output  1  sticky hopper timeout flag
remaining  output  8  amount still unpaid

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. coin_req=0, coin_type=0, busy=0, done=0, short_change=0, fault=0, remaining=0, timeout counter=0.
- All outputs are registered.
- State IDLE:
  - change_valid=1 and change_amount!=0: remaining<=change_amount, busy<=1, short_change<=0, go SELECT.
  - change_valid=1 and change_amount==0: go DONE, no coins paid.
- State SELECT (one cycle):
  - remaining==0 -> DONE.
  - Otherwise pick the lowest index i with DENi<=remaining and coin_empty[i]==0. Set coin_type<=i, clear the timeout counter, go REQ.
  - No such i -> short_change<=1, go DONE with remaining left unchanged.
- State REQ: coin_req=1, coin_type stable.
  - coin_ack=1: remaining<=remaining-DEN[coin_type] (never underflows, by SELECT rule), coin_req<=0, go GAP.
  - Otherwise the counter increments. If the counter reaches ACK_TIMEOUT-1 with no ack: coin_req<=0, fault<=1, busy<=1, go FAULT.
- State GAP: coin_req=0; wait for coin_ack=0, then go SELECT. This completes the four-phase handshake; ack held high stalls here indefinitely.
- State DONE: done=1 for exactly one cycle, busy<=0, go IDLE.
- State FAULT: terminal until reset.
  - coin_req=0, busy=1, fault=1.
  - change_valid is ignored.
  - done is not pulsed.
- Latency: change_valid at edge N -> SELECT during N+1 -> coin_req high after edge N+2. Each coin costs at least 3 cycles (SELECT, REQ, GAP).
- change_valid while busy: ignored, with no effect on remaining or the current payout.
- coin_ack while not in REQ: ignored.
- coin_empty changing mid-payout: takes effect at the next SELECT; a coin already requested is not cancelled.
- Greedy selection with skipped empties can yield short_change even when an exact combination exists. This is accepted, specified behaviour.
- Reset mid-payout: all state is lost, coin_req drops immediately, and the unpaid remainder is not retained.

Test Plan:
- Zero change: change_valid with amount 0 -> done pulse 2 cycles later, coin_req never rises, short_change=0.
- Exact change, all tubes full, amount 37, immediate single-cycle acks:
  - coin_type sequence is 0,1,2,3 (20+10+5+2).
  - remaining steps 37->17->7->2->0.
  - done with short_change=0, then busy=0.
- Empty tube: coin_empty=5'b00010 (tube 1 empty), amount 37 -> sequence 0,2,2,2,3 (20+5+5+5+2), remaining 0, short_change=0.
- Short change: coin_empty=5'b11000, amount 3 -> no coin requested, done with short_change=1 and remaining=3.
- Timeout: amount 25, coin_ack held 0 -> coin_req high for ACK_TIMEOUT-1 cycles then drops, fault=1 sticky, busy=1, no done. A later change_valid is ignored until reset.
- Busy/reset interaction:
  - Second change_valid with amount 50 mid-payout of 25 -> ignored, the original 25 completes (0,2).
  - Reset asserted while coin_req=1 -> all outputs 0 immediately.
  - After release, a fresh payout of 1 works (type 4).
